ex_stage: RTL and testbench

- Execute stage of the 5-stage CPU; consumes every output of the ID/EX pipeline register and feeds the EX/MEM register.
- Contains the ALU, a registered condition-flag register (Z/N/C/V) written by compare instructions, branch/jump/call/returni resolution, and an iterative 32-cycle shift-add multiplier.
- While the multiplier is working, the block holds the ID/EX register and everything upstream with a stall request.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/ex_mul_iter.sv | 89 ++++++++
 rtl/ex_stage.sv | 118 +++++++++++
 tb/tb_ex_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions used by the execute stage.
//   - 5-bit opcode encodings
//   - condition-flag bit positions inside flags[3:0] = {Z,N,C,V}
//   - iterative multiplier state enum
//   - calc_flags(): flag image of a - b for compare instructions
package cpu_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_XOR  = 5'h05;
  localparam logic [4:0] OP_SLL  = 5'h06;
  localparam logic [4:0] OP_SRL  = 5'h07;
  localparam logic [4:0] OP_SRA  = 5'h08;
  localparam logic [4:0] OP_ADDI = 5'h09;
  localparam logic [4:0] OP_MUL  = 5'h0A;
  localparam logic [4:0] OP_LD   = 5'h0F;
  localparam logic [4:0] OP_BEQ  = 5'h10;
  localparam logic [4:0] OP_BNE  = 5'h11;
  localparam logic [4:0] OP_BLT  = 5'h12;
  localparam logic [4:0] OP_BGE  = 5'h13;
  localparam logic [4:0] OP_JMP  = 5'h14;
  localparam logic [4:0] OP_ST   = 5'h15;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  // Flags of a - b. C is "no borrow", V is signed overflow of the subtract.
  function automatic logic [3:0] calc_flags(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    logic [3:0]  f;
    d         = {1'b0, a} - {1'b0, b};
    f[FLAG_Z] = (d[31:0] == 32'h0);
    f[FLAG_N] = d[31];
    f[FLAG_C] = ~d[32];
    f[FLAG_V] = (a[31] ^ b[31]) & (d[31] ^ a[31]);
    return f;
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier, one partial product per cycle.
//   IDLE -> BUSY (MUL_CYCLES iterations) -> DONE -> IDLE.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           MUL present in EX (already qualified by flush)
//   flush           abandon the operation, back to IDLE
//   a, b            multiplicand / multiplier, sampled on start in IDLE
//   busy            stall request: start cycle in IDLE plus every BUSY cycle
//   done            product valid (DONE state)
//   product         low DATA_W bits of a*b
module ex_mul_iter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  import cpu_pkg::*;

  localparam int unsigned     CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_e        state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (flush) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
        BUSY: begin
          // Only the low DATA_W product bits are kept, so the multiplicand
          // may simply shift out of the top.
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CNT_W'(1);
          if (count_q == LAST) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  assign busy    = !flush && ((state_q == IDLE && start) || state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. ALU, registered Z/N/C/V flags written by compares,
// branch/jump/call/returni resolution and (optionally) an iterative multiplier.
// Build option: define EX_MUL_EN to include the multiplier; otherwise MUL
// behaves as NOP and stall_req is constant 0.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 kill the current op (no redirect, no flag write, no stall)
//   opcode, rd1, rd2,     ID/EX operands
//   sign_ext_imm, pc_plus_4, cmp, call, returni
//   ex_result             ALU / product / link value
//   store_data            rd2 pass-through
//   branch_taken/target   fetch redirect
//   flags                 {Z,N,C,V}
//   stall_req             multiplier in progress
module ex_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic [DATA_W-1:0] sign_ext_imm,
  input  logic [DATA_W-1:0] pc_plus_4,
  input  logic              cmp,
  input  logic              call,
  input  logic              returni,
  output logic [DATA_W-1:0] ex_result,
  output logic [DATA_W-1:0] store_data,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic [3:0]        flags,
  output logic              stall_req
);
  import cpu_pkg::*;

  logic              mul_busy, mul_done;
  logic [DATA_W-1:0] mul_prod;

`ifdef EX_MUL_EN
  ex_mul_iter #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (opcode == OP_MUL && !flush),
    .flush   (flush),
    .a       (rd1),
    .b       (rd2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  logic unused_cfg;
  assign unused_cfg = |MUL_CYCLES;
  assign mul_busy   = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_prod   = '0;
`endif

  // ALU / result select
  always_comb begin
    ex_result = '0;
    case (opcode)
      OP_ADD:               ex_result = rd1 + rd2;
      OP_SUB:               ex_result = rd1 - rd2;
      OP_AND:               ex_result = rd1 & rd2;
      OP_OR:                ex_result = rd1 | rd2;
      OP_XOR:               ex_result = rd1 ^ rd2;
      OP_SLL:               ex_result = rd1 << rd2[4:0];
      OP_SRL:               ex_result = rd1 >> rd2[4:0];
      OP_SRA:               ex_result = $signed(rd1) >>> rd2[4:0];
      OP_ADDI, OP_LD, OP_ST: ex_result = rd1 + sign_ext_imm;
      // Product only in DONE; earlier cycles are bubbles into EX/MEM anyway.
      OP_MUL:               ex_result = mul_done ? mul_prod : '0;
      default:              ex_result = '0;
    endcase
    if (call) ex_result = pc_plus_4;
  end

  assign store_data = rd2;

  // Flags
  logic [3:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (cmp && !flush) flags_d = calc_flags(rd1, rd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;

  // Branch resolution from the registered flags, so a compare in the
  // previous cycle is already visible here.
  logic uncond, cond;

  always_comb begin
    uncond = call || returni || (opcode == OP_JMP);
    case (opcode)
      OP_BEQ:  cond =  flags_q[FLAG_Z];
      OP_BNE:  cond = !flags_q[FLAG_Z];
      OP_BLT:  cond =  flags_q[FLAG_N] ^ flags_q[FLAG_V];
      OP_BGE:  cond = !(flags_q[FLAG_N] ^ flags_q[FLAG_V]);
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken  = !flush && (opcode != OP_MUL) && (uncond || cond);
  assign branch_target = uncond ? rd1 : pc_plus_4 + (sign_ext_imm << 2);
  assign stall_req     = mul_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed literal cases plus randomized instruction
// stream compared each cycle against a behavioural model.
// Honors EX_MUL_EN the same way the design does.
module tb_ex_stage;

`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [4:0]  opcode = 5'h0;
  logic [31:0] rd1 = '0, rd2 = '0, imm = '0, pc4 = '0;
  logic        cmp = 1'b0, call = 1'b0, returni = 1'b0;
  logic [31:0] ex_result, store_data, branch_target;
  logic        branch_taken, stall_req;
  logic [3:0]  flags;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .opcode(opcode),
    .rd1(rd1), .rd2(rd2), .sign_ext_imm(imm), .pc_plus_4(pc4),
    .cmp(cmp), .call(call), .returni(returni),
    .ex_result(ex_result), .store_data(store_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .flags(flags), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_flags = '0;
  int          m_age = 0;      // cycles since a MUL started; 0 = none in flight
  logic [31:0] m_prod = '0;

  function automatic logic [3:0] model_flags(input logic [31:0] a, input logic [31:0] b);
    longint sd;
    logic [31:0] r;
    sd = longint'($signed(a)) - longint'($signed(b));
    r  = a - b;
    return {r == 32'h0, r[31], a >= b, (sd > 64'sd2147483647) || (sd < -64'sd2147483648)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flags <= '0;
      m_age   <= 0;
      m_prod  <= '0;
    end else begin
      if (cmp && !flush) m_flags <= model_flags(rd1, rd2);
      if (MUL_EN) begin
        if (flush)                 m_age <= 0;
        else if (m_age == 0) begin
          if (opcode == 5'h0A) begin
            m_age  <= 1;
            m_prod <= rd1 * rd2;
          end
        end else if (m_age < 33)   m_age <= m_age + 1;
        else                       m_age <= 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] e_res, e_tgt;
    logic        e_tk, e_st, unc, cnd;
    int          s;
    s = int'(rd2[4:0]);
    case (opcode)
      5'h01: e_res = rd1 + rd2;
      5'h02: e_res = rd1 - rd2;
      5'h03: e_res = rd1 & rd2;
      5'h04: e_res = rd1 | rd2;
      5'h05: e_res = rd1 ^ rd2;
      5'h06: e_res = rd1 << s;
      5'h07: e_res = rd1 >> s;
      5'h08: e_res = (rd1 >> s) | (rd1[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      5'h09, 5'h0F, 5'h15: e_res = rd1 + imm;
      5'h0A: e_res = (m_age == 33) ? m_prod : 32'h0;
      default: e_res = 32'h0;
    endcase
    if (call) e_res = pc4;
    unc = call || returni || opcode == 5'h14;
    case (opcode)
      5'h10: cnd = m_flags[3];
      5'h11: cnd = !m_flags[3];
      5'h12: cnd = m_flags[2] != m_flags[0];
      5'h13: cnd = m_flags[2] == m_flags[0];
      default: cnd = 1'b0;
    endcase
    e_tk  = !flush && opcode != 5'h0A && (unc || cnd);
    e_tgt = unc ? rd1 : pc4 + imm * 4;
    e_st  = MUL_EN && !flush && ((m_age == 0 && opcode == 5'h0A) || (m_age >= 1 && m_age <= 32));
    chk("ex_result", ex_result, e_res);
    chk("store_data", store_data, rd2);
    chk("branch_taken", {31'b0, branch_taken}, {31'b0, e_tk});
    if (e_tk) chk("branch_target", branch_target, e_tgt);
    chk("flags", {28'b0, flags}, {28'b0, m_flags});
    chk("stall_req", {31'b0, stall_req}, {31'b0, e_st});
  end

  // ---------------- stimulus ----------------
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] pc, input logic c,
                       input logic cl, input logic rt);
    opcode = op; rd1 = a; rd2 = b; imm = im; pc4 = pc;
    cmp = c; call = cl; returni = rt; flush = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Runs a MUL already on the inputs; returns stall cycles seen (bounded).
  task automatic run_mul(output int st);
    st = 0;
    @(negedge clk);
    while (stall_req && st < 40) begin
      st++;
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int st;
    logic [4:0] ops [0:22];
    ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
            5'h0F, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h1F, 5'h10, 5'h12, 5'h13};
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_flags", {28'b0, flags}, 32'h0);
    chk("reset_stall", {31'b0, stall_req}, 32'h0);
    chk("reset_result", ex_result, 32'h0);
    chk("reset_target", branch_target, 32'h0);
    go(); rst_n = 1'b1;

    setop(5'h01, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("add_wrap", ex_result, 32'h0);
    go(); setop(5'h08, 32'h8000_0000, 32'd4, 0, 0, 0, 0, 0);
    @(negedge clk); chk("sra", ex_result, 32'hF800_0000);
    go(); setop(5'h09, 32'd10, 32'd0, 32'hFFFF_FFFD, 0, 0, 0, 0);
    @(negedge clk); chk("addi_neg", ex_result, 32'd7);

    go(); setop(5'h02, 32'd5, 32'd7, 0, 0, 1, 0, 0);
    go(); setop(5'h12, 0, 0, 32'd4, 32'h100, 0, 0, 0);
    @(negedge clk);
    chk("cmp_flags", {28'b0, flags}, 32'h4);
    chk("blt_taken", {31'b0, branch_taken}, 32'h1);
    chk("blt_target", branch_target, 32'h110);
    go(); setop(5'h02, 32'd5, 32'd7, 0, 0, 1, 0, 0);
    go(); setop(5'h13, 0, 0, 32'd4, 32'h100, 0, 0, 0);
    @(negedge clk); chk("bge_not_taken", {31'b0, branch_taken}, 32'h0);

    if (MUL_EN) begin
      go(); setop(5'h0A, 32'd12345, 32'd678, 0, 0, 0, 0, 0);
      run_mul(st);
      chk("mul_stall_cycles", st, 33);
      chk("mul_product", ex_result, 32'd8369910);
      go(); setop(5'h0A, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0, 0);
      run_mul(st);
      chk("mul_neg_stall", st, 33);
      chk("mul_neg_product", ex_result, 32'hFFFF_FFFE);

      go(); setop(5'h0A, 32'd7, 32'd9, 0, 0, 0, 0, 0);
      repeat (11) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk); chk("flush_stall", {31'b0, stall_req}, 32'h0);
      go(); setop(5'h01, 32'd3, 32'd4, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("add_after_flush", ex_result, 32'd7);
      chk("add_after_flush_stall", {31'b0, stall_req}, 32'h0);

      go(); setop(5'h0A, 32'd100, 32'd200, 0, 0, 0, 0, 0);
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      setop(5'h00, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_mid_mul_flags", {28'b0, flags}, 32'h0);
      chk("rst_mid_mul_stall", {31'b0, stall_req}, 32'h0);
      go(); rst_n = 1'b1;
    end else begin
      go(); setop(5'h0A, 32'd3, 32'd4, 0, 0, 0, 0, 0);
      repeat (3) begin
        @(negedge clk);
        chk("mul_disabled_result", ex_result, 32'h0);
        chk("mul_disabled_stall", {31'b0, stall_req}, 32'h0);
      end
    end

    go(); setop(5'h00, 32'h400, 0, 0, 32'h24, 0, 1, 0);
    @(negedge clk);
    chk("call_taken", {31'b0, branch_taken}, 32'h1);
    chk("call_target", branch_target, 32'h400);
    chk("call_link", ex_result, 32'h24);

    // Random stream; inputs are held while the model says a MUL is in flight.
    for (int i = 0; i < 800; i++) begin
      go();
      if (m_age >= 1 && m_age <= 33) begin
        flush = ($urandom % 40) == 0;
      end else begin
        setop(ops[$urandom % 23], rnd_val(), rnd_val(), rnd_val(), $urandom, 1'b0, 1'b0, 1'b0);
        if (($urandom % 4) == 0) rd2 = $urandom % 32;
        if (opcode != 5'h0A) begin
          cmp     = ($urandom % 3) == 0;
          call    = ($urandom % 15) == 0;
          returni = ($urandom % 15) == 0;
        end
        flush = ($urandom % 25) == 0;
      end
    end

    go(); setop(5'h00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
